alu_sequencer: RTL and testbench

- Multi-cycle initiator that drives the operand/select side of an external combinational `alu` instance and consumes its `out`.
- Adds unsigned multiply (shift-add) and unsigned divide (restoring) to the datapath.
- Uses only the ALU operations ALU_ADD, ALU_SUB, ALU_GT and ALU_NOP.
- Sits beside the ALU in the execute stage; the control unit stalls on `busy` and captures results on `done`.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Function-select encoding shared by the execute-stage alu and the units that drive it.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_GT  = 3'd3
    } alu_func_t;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) built on an
// external combinational alu; hi/lo hold the product halves or remainder/quotient.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int length = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [length-1:0] a_in,
    input  logic [length-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic [length-1:0] result_hi,
    output logic [length-1:0] result_lo,
    output logic              div_by_zero,
    output logic [length-1:0] alu_a,
    output logic [length-1:0] alu_b,
    output alu_func_t         alu_sel,
    input  logic [length-1:0] alu_out
);

    typedef enum logic [2:0] {IDLE, MUL_STEP, DIV_CMP, DIV_SUB, FINISH} state_t;

    localparam int CW = (length > 1) ? $clog2(length) : 1;
    localparam logic [CW-1:0] LAST = CW'(length - 1);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [length-1:0] hi, lo, opnd;
    logic              ext, ge, dbz_pend;

    logic [length-1:0] mul_sum, rem_n, quo_n;
    logic              mul_carry;

    // The alu add wraps, so a carry out shows up as a sum smaller than the addend.
    assign mul_sum   = lo[0] ? alu_out : hi;
    assign mul_carry = lo[0] & (alu_out < hi);
    assign rem_n     = ge ? alu_out : hi;
    assign quo_n     = {lo[length-1:1], ge};

    always_comb begin
        state_nx = state;
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = ALU_NOP;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op)              state_nx = MUL_STEP;
                    else if (b_in == '0)  state_nx = FINISH;
                    else                  state_nx = DIV_CMP;
                end
            end
            MUL_STEP: begin
                alu_a   = hi;
                alu_b   = opnd;
                alu_sel = ALU_ADD;
                if (cnt == LAST) state_nx = FINISH;
            end
            DIV_CMP: begin
                alu_a    = opnd;
                alu_b    = hi;
                alu_sel  = ALU_GT;
                state_nx = DIV_SUB;
            end
            DIV_SUB: begin
                alu_a    = hi;
                alu_b    = opnd;
                alu_sel  = ALU_SUB;
                state_nx = (cnt == LAST) ? FINISH : DIV_CMP;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control and visible results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state != IDLE);
            done  <= (state == FINISH);
            if (state == MUL_STEP || state == DIV_SUB)
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (state == IDLE && start)
                div_by_zero <= 1'b0;
            if (state == FINISH) begin
                result_hi   <= hi;
                result_lo   <= lo;
                div_by_zero <= dbz_pend;
            end
        end
    end

    // Datapath; each divide bit starts with {ext,hi,lo} already shifted left.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    opnd     <= op ? b_in : a_in;
                    dbz_pend <= op && (b_in == '0);
                    ext      <= 1'b0;
                    if (!op) begin
                        hi <= '0;
                        lo <= b_in;
                    end else if (b_in == '0) begin
                        hi <= a_in;
                        lo <= '1;
                    end else begin
                        hi <= {{(length-1){1'b0}}, a_in[length-1]};
                        lo <= {a_in[length-2:0], 1'b0};
                    end
                end
            end
            MUL_STEP: begin
                hi <= {mul_carry, mul_sum[length-1:1]};
                lo <= {mul_sum[0], lo[length-1:1]};
            end
            DIV_CMP: ge <= ext | (alu_out == '0);
            DIV_SUB: begin
                if (cnt == LAST) begin
                    ext <= 1'b0;
                    hi  <= rem_n;
                    lo  <= quo_n;
                end else begin
                    ext <= rem_n[length-1];
                    hi  <= {rem_n[length-2:0], quo_n[length-1]};
                    lo  <= {quo_n[length-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural alu attached to its initiator side.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk, rst, start, op;
    logic [15:0] a_in, b_in;
    logic        busy, done, div_by_zero;
    logic [15:0] result_hi, result_lo, alu_a, alu_b, alu_out;
    alu_func_t   alu_sel;

    int nvec = 0;
    int nerr = 0;

    int          lat, bc;
    logic [15:0] rh, rl;
    logic        rd, rok;

    alu_sequencer #(.length(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_out(alu_out)
    );

    always_comb begin
        case (alu_sel)
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_GT:  alu_out = (alu_a > alu_b) ? 16'd1 : 16'd0;
            default: alu_out = 16'd0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; start is sampled at the following edge ("edge 0").
    // lat = edge count after which done was seen (0 = never within the bound).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic o,
                          input int poke_at, input int poke2, input int rst_at,
                          output int lt, output int bcnt, output logic [15:0] hi,
                          output logic [15:0] lo, output logic dz, output logic rok_o);
        a_in = a; b_in = b; op = o; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lt = 0; bcnt = 0; hi = '0; lo = '0; dz = 1'b0; rok_o = 1'b1;
        for (int k = 1; k <= 60 && lt == 0; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                rst = 1'b0;
                if (busy !== 1'b0 || done !== 1'b0) rok_o = 1'b0;
            end
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                lt = k; hi = result_hi; lo = result_lo; dz = div_by_zero;
            end
            start = (lt == 0) && (k == poke_at || k == poke_at + 1 || k == poke2);
            if (start) begin a_in = 16'h0009; b_in = 16'h0000; op = 1'b1; end
            if (k == rst_at - 1) rst = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset busy: got %b want 0", busy); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset done: got %b want 0", done); end
        nvec++; if (result_hi !== 16'h0 || result_lo !== 16'h0) begin
            nerr++; $display("FAIL reset results: got %h/%h want 0000/0000", result_hi, result_lo); end
        nvec++; if (div_by_zero !== 1'b0) begin nerr++; $display("FAIL reset dbz: got %b want 0", div_by_zero); end
        nvec++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_sel !== ALU_NOP) begin
            nerr++; $display("FAIL reset alu: got a=%h b=%h sel=%0d want 0/0/NOP", alu_a, alu_b, alu_sel); end
    endtask

    task automatic test_multiply();
        run_op(16'd3, 16'd5, 1'b0, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (lat !== 17) begin nerr++; $display("FAIL mul3x5 latency: got %0d want 17", lat); end
        nvec++; if (rh !== 16'h0000 || rl !== 16'h000F) begin
            nerr++; $display("FAIL mul3x5 result: got %h/%h want 0000/000f", rh, rl); end
        nvec++; if (bc !== 17) begin nerr++; $display("FAIL mul3x5 busy cycles: got %0d want 17", bc); end
        @(negedge clk);
        nvec++; if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++; $display("FAIL mul3x5 after done: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_mul_carry();
        run_op(16'hFFFF, 16'hFFFF, 1'b0, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (rh !== 16'hFFFE || rl !== 16'h0001) begin
            nerr++; $display("FAIL mulffff result: got %h/%h want fffe/0001", rh, rl); end
        run_op(16'h8000, 16'h0002, 1'b0, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (rh !== 16'h0001 || rl !== 16'h0000) begin
            nerr++; $display("FAIL mul8000x2 result: got %h/%h want 0001/0000", rh, rl); end
    endtask

    task automatic test_divide();
        run_op(16'd100, 16'd7, 1'b1, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (lat !== 33) begin nerr++; $display("FAIL div100/7 latency: got %0d want 33", lat); end
        nvec++; if (rl !== 16'd14 || rh !== 16'd2 || rd !== 1'b0) begin
            nerr++; $display("FAIL div100/7 result: got q=%0d r=%0d dz=%b want 14/2/0", rl, rh, rd); end
        nvec++; if (bc !== 33) begin nerr++; $display("FAIL div100/7 busy cycles: got %0d want 33", bc); end
        run_op(16'hFFFF, 16'h0001, 1'b1, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (rl !== 16'hFFFF || rh !== 16'h0000) begin
            nerr++; $display("FAIL divffff/1 result: got q=%h r=%h want ffff/0000", rl, rh); end
        run_op(16'h1234, 16'hFFFF, 1'b1, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (rl !== 16'h0000 || rh !== 16'h1234) begin
            nerr++; $display("FAIL div1234/ffff result: got q=%h r=%h want 0000/1234", rl, rh); end
    endtask

    task automatic test_div_by_zero();
        run_op(16'h00AB, 16'h0000, 1'b1, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (lat !== 1) begin nerr++; $display("FAIL dbz latency: got %0d want 1", lat); end
        nvec++; if (rd !== 1'b1 || rl !== 16'hFFFF || rh !== 16'h00AB) begin
            nerr++; $display("FAIL dbz result: got dz=%b q=%h r=%h want 1/ffff/00ab", rd, rl, rh); end
        repeat (3) @(negedge clk);
        nvec++; if (div_by_zero !== 1'b1 || result_lo !== 16'hFFFF || result_hi !== 16'h00AB) begin
            nerr++; $display("FAIL dbz hold: got dz=%b q=%h r=%h want 1/ffff/00ab", div_by_zero, result_lo, result_hi); end
        run_op(16'd10, 16'd3, 1'b1, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (rd !== 1'b0 || rl !== 16'd3 || rh !== 16'd1) begin
            nerr++; $display("FAIL dbz clear: got dz=%b q=%0d r=%0d want 0/3/1", rd, rl, rh); end
    endtask

    task automatic test_hazards();
        // start pulses mid-multiply and in the FINISH cycle must be ignored
        run_op(16'd6, 16'd7, 1'b0, 5, 16, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (lat !== 17 || rl !== 16'd42 || rh !== 16'd0 || rd !== 1'b0) begin
            nerr++; $display("FAIL busy start: got lat=%0d r=%h/%h dz=%b want 17/0000/002a/0", lat, rh, rl, rd); end
        repeat (2) @(negedge clk);
        nvec++; if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++; $display("FAIL finish start: got busy=%b done=%b want 0/0", busy, done); end
        // reset at edge 8 of a multiply
        run_op(16'd3, 16'd5, 1'b0, -5, -5, 8, lat, bc, rh, rl, rd, rok);
        nvec++; if (rok !== 1'b1) begin nerr++; $display("FAIL midrst idle: got rok=%b want 1", rok); end
        nvec++; if (lat !== 0) begin nerr++; $display("FAIL midrst done: got done at %0d want never", lat); end
        // second start issued in the done cycle of the first
        run_op(16'h1234, 16'h0010, 1'b0, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (rh !== 16'h0001 || rl !== 16'h2340) begin
            nerr++; $display("FAIL b2b first: got %h/%h want 0001/2340", rh, rl); end
        run_op(16'd1000, 16'd10, 1'b1, -5, -5, -5, lat, bc, rh, rl, rd, rok);
        nvec++; if (lat !== 33 || rl !== 16'd100 || rh !== 16'd0) begin
            nerr++; $display("FAIL b2b second: got lat=%0d q=%0d r=%0d want 33/100/0", lat, rl, rh); end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_mul_carry();
        test_divide();
        test_div_by_zero();
        test_hazards();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
